// File: rtl/lsq_data_memory.sv
// lsq_data_memory: multi-cycle data memory port behind the load/store queue.
// Takes one load or store at a time, waits a fixed latency, then performs a
// byte or word access on a small big-endian byte RAM. The result goes back
// tagged with the ROB index so the CDB/ROB can write it back.
module lsq_data_memory #(
  parameter int MEM_BYTES     = 32,
  parameter int ADDR_W        = $clog2(MEM_BYTES),
  parameter int REG_SIZE      = 32,
  parameter int ROB_SIZE_LOG2 = 6,
  parameter int LATENCY       = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_is_store,
  input  logic                     req_is_word,
  input  logic                     req_is_signed,
  input  logic [REG_SIZE-1:0]      req_addr,
  input  logic [REG_SIZE-1:0]      req_wdata,
  input  logic [ROB_SIZE_LOG2-1:0] req_rob_index,
  input  logic                     flush,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_is_store,
  output logic [REG_SIZE-1:0]      resp_data,
  output logic [ROB_SIZE_LOG2-1:0] resp_rob_index
);

  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [CNT_W-1:0]         cnt;
  logic                     lat_is_store;
  logic                     lat_is_word;
  logic                     lat_is_signed;
  logic [ADDR_W-1:0]        lat_idx;
  logic [REG_SIZE-1:0]      lat_wdata;
  logic [ROB_SIZE_LOG2-1:0] lat_rob_index;

  logic [7:0] mem [MEM_BYTES];

  // Upper address bits alias onto the RAM and are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[REG_SIZE-1:ADDR_W];

  // Word byte indices wrap naturally in ADDR_W-bit arithmetic.
  logic [ADDR_W-1:0] idx0;
  logic [ADDR_W-1:0] idx1;
  logic [ADDR_W-1:0] idx2;
  logic [ADDR_W-1:0] idx3;
  assign idx0 = lat_idx;
  assign idx1 = lat_idx + ADDR_W'(1);
  assign idx2 = lat_idx + ADDR_W'(2);
  assign idx3 = lat_idx + ADDR_W'(3);

  logic accept;
  logic cancel;
  logic access;
  logic release_resp;
  logic [REG_SIZE-1:0] load_data;

  assign req_ready = (state == IDLE);

  // Next-state and control strobes; flush only ever cancels loads.
  always_comb begin
    next_state   = state;
    accept       = 1'b0;
    access       = 1'b0;
    release_resp = 1'b0;
    cancel       = flush && !lat_is_store;
    case (state)
      IDLE: begin
        if (req_valid && !flush) begin
          accept     = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (cancel) begin
          next_state = IDLE;
        end else if (cnt == '0) begin
          access     = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        if ((resp_valid && resp_ready) || cancel) begin
          release_resp = 1'b1;
          next_state   = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Load result assembled big-endian; byte loads optionally sign-extend.
  always_comb begin
    load_data = '0;
    if (lat_is_word) begin
      load_data = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};
    end else begin
      load_data = {{(REG_SIZE-8){lat_is_signed & mem[idx0][7]}}, mem[idx0]};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request latch and latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      lat_is_store  <= 1'b0;
      lat_is_word   <= 1'b0;
      lat_is_signed <= 1'b0;
      lat_idx       <= '0;
      lat_wdata     <= '0;
      lat_rob_index <= '0;
    end else if (accept) begin
      cnt           <= CNT_W'(LATENCY - 1);
      lat_is_store  <= req_is_store;
      lat_is_word   <= req_is_word;
      lat_is_signed <= req_is_signed;
      lat_idx       <= req_addr[ADDR_W-1:0];
      lat_wdata     <= req_wdata;
      lat_rob_index <= req_rob_index;
    end else if (state == BUSY && !cancel && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // RAM: cleared on reset, written only when a store's access fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (access && lat_is_store) begin
      if (lat_is_word) begin
        mem[idx0] <= lat_wdata[31:24];
        mem[idx1] <= lat_wdata[23:16];
        mem[idx2] <= lat_wdata[15:8];
        mem[idx3] <= lat_wdata[7:0];
      end else begin
        mem[idx0] <= lat_wdata[7:0];
      end
    end
  end

  // Response registers, held stable until taken or cancelled.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid     <= 1'b0;
      resp_is_store  <= 1'b0;
      resp_data      <= '0;
      resp_rob_index <= '0;
    end else if (access) begin
      resp_valid     <= 1'b1;
      resp_is_store  <= lat_is_store;
      resp_data      <= lat_is_store ? '0 : load_data;
      resp_rob_index <= lat_rob_index;
    end else if (release_resp) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsq_data_memory.sv
// Testbench for lsq_data_memory: directed scenarios plus randomized traffic,
// checked against a byte-array reference model of the RAM.
module tb_lsq_data_memory;

  localparam int LATENCY = 10;
  localparam int MEM_BYTES = 32;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic        req_is_word;
  logic        req_is_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [5:0]  req_rob_index;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_is_store;
  logic [31:0] resp_data;
  logic [5:0]  resp_rob_index;

  int n_checks = 0;
  int n_fail = 0;

  byte unsigned ref_mem [MEM_BYTES];

  lsq_data_memory #(
    .MEM_BYTES(MEM_BYTES),
    .REG_SIZE(32),
    .ROB_SIZE_LOG2(6),
    .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_is_store(req_is_store),
    .req_is_word(req_is_word),
    .req_is_signed(req_is_signed),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_rob_index(req_rob_index),
    .flush(flush),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_is_store(resp_is_store),
    .resp_data(resp_data),
    .resp_rob_index(resp_rob_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference load: big-endian byte sum, wrapping modulo RAM size.
  function automatic logic [31:0] modelLoad(input logic [31:0] addr, input bit is_word, input bit is_signed);
    int base;
    longint unsigned acc;
    base = int'(addr % MEM_BYTES);
    acc = 0;
    if (is_word) begin
      for (int k = 0; k < 4; k++) begin
        acc = acc * 256 + ref_mem[(base + k) % MEM_BYTES];
      end
    end else begin
      acc = ref_mem[base];
      if (is_signed && acc >= 128) acc = acc + 64'hFFFF_FF00;
    end
    return acc[31:0];
  endfunction

  // Reference store: most significant byte lands at the lowest address.
  task automatic modelStore(input logic [31:0] addr, input logic [31:0] wdata, input bit is_word);
    int base;
    logic [31:0] v;
    base = int'(addr % MEM_BYTES);
    v = wdata;
    if (is_word) begin
      for (int k = 3; k >= 0; k--) begin
        ref_mem[(base + k) % MEM_BYTES] = v[7:0];
        v = v >> 8;
      end
    end else begin
      ref_mem[base] = v[7:0];
    end
  endtask

  // One full transaction: issue, time the response, check it, then release it
  // by handshake or by a flush. flush_at > 0 pulses flush during BUSY.
  task automatic applyStimulus(input bit st, input bit wd, input bit sg,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [5:0] rob, input int hold,
                               input int flush_at, input bit flush_resp);
    logic [31:0] exp_data;
    int k;
    int wait_cnt;
    bit seen;
    exp_data = st ? 32'h0 : modelLoad(addr, wd, sg);
    wait_cnt = 0;
    while (!req_ready && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    checkOutput("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_is_store = st;
    req_is_word = wd;
    req_is_signed = sg;
    req_addr = addr;
    req_wdata = wdata;
    req_rob_index = rob;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr = $urandom;
    checkOutput("req_ready_busy", {31'h0, req_ready}, 32'h0);
    seen = 1'b0;
    for (k = 1; k <= LATENCY + 4; k++) begin
      if (k == flush_at) flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      if (k == flush_at && !st) break;
    end
    if (flush_at > 0 && !st) begin
      checkOutput("flush_busy_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("flush_busy_noresp", {31'h0, resp_valid}, 32'h0);
      seen = 1'b0;
      repeat (LATENCY + 2) begin
        @(posedge clk); #1;
        if (resp_valid) seen = 1'b1;
      end
      checkOutput("flush_busy_silent", {31'h0, seen}, 32'h0);
      return;
    end
    checkOutput("resp_seen", {31'h0, seen}, 32'h1);
    if (!seen) return;
    checkOutput("latency", k, LATENCY);
    checkOutput("resp_is_store", {31'h0, resp_is_store}, {31'h0, st});
    checkOutput("resp_data", resp_data, exp_data);
    checkOutput("resp_rob", {26'h0, resp_rob_index}, {26'h0, rob});
    checkOutput("resp_req_ready", {31'h0, req_ready}, 32'h0);
    if (st) modelStore(addr, wdata, wd);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", {31'h0, resp_valid}, 32'h1);
      checkOutput("hold_data", resp_data, exp_data);
      checkOutput("hold_rob", {26'h0, resp_rob_index}, {26'h0, rob});
      checkOutput("hold_req_ready", {31'h0, req_ready}, 32'h0);
    end
    if (flush_resp) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checkOutput("flush_resp_valid", {31'h0, resp_valid}, 32'h0);
      checkOutput("flush_resp_ready", {31'h0, req_ready}, 32'h1);
    end else begin
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      checkOutput("taken_valid", {31'h0, resp_valid}, 32'h0);
      checkOutput("taken_ready", {31'h0, req_ready}, 32'h1);
    end
  endtask

  // Global safety net in case the design wedges inside an unbounded path.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    bit any_valid;
    rst = 1'b1;
    req_valid = 1'b0;
    req_is_store = 1'b0;
    req_is_word = 1'b0;
    req_is_signed = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_rob_index = '0;
    flush = 1'b0;
    resp_ready = 1'b0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("rst_resp_is_store", {31'h0, resp_is_store}, 32'h0);
    checkOutput("rst_resp_data", resp_data, 32'h0);
    checkOutput("rst_resp_rob", {26'h0, resp_rob_index}, 32'h0);
    applyStimulus(0, 1, 0, 32'h0, 32'h0, 6'd1, 0, 0, 0);

    $display("[TB] store then loads");
    applyStimulus(1, 1, 0, 32'h4, 32'hDEADBEEF, 6'd3, 0, 0, 0);
    applyStimulus(0, 1, 0, 32'h4, 32'h0, 6'd5, 0, 0, 0);
    applyStimulus(0, 0, 0, 32'h5, 32'h0, 6'd6, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h5, 32'h0, 6'd7, 0, 0, 0);

    $display("[TB] wrap and alias");
    applyStimulus(1, 1, 0, 32'd30, 32'h11223344, 6'd8, 0, 0, 0);
    applyStimulus(0, 0, 0, 32'd30, 32'h0, 6'd9, 0, 0, 0);
    applyStimulus(0, 0, 0, 32'd31, 32'h0, 6'd10, 0, 0, 0);
    applyStimulus(0, 0, 0, 32'd0, 32'h0, 6'd11, 0, 0, 0);
    applyStimulus(0, 0, 0, 32'd1, 32'h0, 6'd12, 0, 0, 0);
    applyStimulus(0, 1, 0, 32'd0, 32'h0, 6'd13, 0, 0, 0);
    applyStimulus(0, 0, 0, 32'h21, 32'h0, 6'd14, 0, 0, 0);

    $display("[TB] backpressure");
    applyStimulus(0, 1, 0, 32'h4, 32'h0, 6'd15, 3, 0, 0);

    $display("[TB] flush");
    applyStimulus(0, 1, 0, 32'h4, 32'h0, 6'd16, 0, 4, 0);
    applyStimulus(0, 1, 0, 32'h4, 32'h0, 6'd17, 1, 0, 1);
    applyStimulus(1, 1, 0, 32'd12, 32'hCAFEF00D, 6'd18, 0, 4, 0);
    applyStimulus(0, 1, 0, 32'd12, 32'h0, 6'd19, 0, 0, 0);

    $display("[TB] reset mid-store");
    req_is_store = 1'b1;
    req_is_word = 1'b0;
    req_is_signed = 1'b0;
    req_addr = 32'd20;
    req_wdata = 32'h0000005A;
    req_rob_index = 6'd20;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    checkOutput("midrst_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("midrst_valid", {31'h0, resp_valid}, 32'h0);
    any_valid = 1'b0;
    repeat (LATENCY + 2) begin
      @(posedge clk); #1;
      if (resp_valid) any_valid = 1'b1;
    end
    checkOutput("midrst_silent", {31'h0, any_valid}, 32'h0);
    applyStimulus(0, 0, 0, 32'd20, 32'h0, 6'd21, 0, 0, 0);
    applyStimulus(0, 1, 0, 32'd12, 32'h0, 6'd22, 0, 0, 0);

    $display("[TB] random traffic");
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom, $urandom,
                    6'($urandom_range(0, 63)), $urandom_range(0, 2), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
